// File: rtl/tsc_serial_receiver.sv
// -----------------------------------------------------------------------------
// tsc_serial_receiver
//   Host-side receiver for the trigger surround cache serial readout.
//   After an arm pulse it waits for the cache trigger, latches the trigger
//   timestamp, requests the buffer with a one-cycle sbf pulse, then
//   deserialises start-bit framed bytes (MSB first) from sd into a local
//   sample RAM until the cache signals completion on cd.
//   Error conditions (overflow, framing, timeout) raise a sticky err flag
//   that is cleared only by the next arm or by reset.
// -----------------------------------------------------------------------------
module tsc_serial_receiver #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned TW     = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          arm_i,
  input  logic          trd_i,
  input  logic [31:0]   trigtm_i,
  input  logic          sd_i,
  input  logic          cd_i,
  output logic          sbf_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic [31:0]   trig_time_o,
  output logic [AW:0]   byte_count_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  // Capture sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // byte_count value at which the sample RAM is full
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  // Last WAIT cycle allowed before the capture is aborted
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   trig_time_q, trig_time_d;
  logic [AW:0]   byte_count_q, byte_count_d;
  logic [6:0]    sreg_q, sreg_d;       // first seven data bits of the byte in flight
  logic [2:0]    bit_cnt_q, bit_cnt_d; // data bits already received in SHIFT
  logic [TW-1:0] tmo_q, tmo_d;         // idle cycles spent waiting for a start bit or cd
  logic          sbf_q, sbf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Sample RAM write port, driven from the deserialiser
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    rd_data_q;

  // Next-state, flag and RAM-write decode for the capture sequencer
  always_comb begin
    state_d      = state_q;
    trig_time_d  = trig_time_q;
    byte_count_d = byte_count_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    sbf_d        = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_waddr    = byte_count_q[AW-1:0];
    mem_wdata    = {sreg_q, sd_i};

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          state_d      = S_ARMED;
          done_d       = 1'b0;
          err_d        = 1'b0;
          byte_count_d = {(AW + 1){1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ARMED: begin
        // sd and cd are meaningless before the buffer is requested
        if (trd_i) begin
          trig_time_d = trigtm_i;
          state_d     = S_REQ;
          sbf_d       = 1'b1; // sbf_q is high exactly while in REQ
        end else begin
          state_d = S_ARMED;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // cd has priority over a coincident start bit, and a start bit on
        // the last allowed cycle still beats the timeout
        if (cd_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (sd_i) begin
          state_d   = S_SHIFT;
          bit_cnt_d = 3'd0;
          if (byte_count_q == CNT_FULL) begin
            // Byte will still be shifted in, but has nowhere to go
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_SHIFT: begin
        // Every cycle here receives a bit and restarts the timeout, so
        // only cd can end the byte early
        if (cd_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          sreg_d    = {sreg_q[5:0], sd_i};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_WAIT;
            if (byte_count_q != CNT_FULL) begin
              mem_we       = 1'b1;
              byte_count_d = byte_count_q + {{AW{1'b0}}, 1'b1};
            end else begin
              byte_count_d = byte_count_q;
            end
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_DONE: begin
        if (arm_i) begin
          state_d      = S_ARMED;
          done_d       = 1'b0;
          err_d        = 1'b0;
          byte_count_d = {(AW + 1){1'b0}};
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == S_ARMED) || (state_d == S_REQ) ||
             (state_d == S_WAIT)  || (state_d == S_SHIFT);
  end

  // Timeout counter: runs only while idling in WAIT, restarts on any state change
  always_comb begin
    if ((state_d != state_q) || (state_q != S_WAIT)) begin
      tmo_d = {TW{1'b0}};
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Sequencer state and registered outputs, synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      trig_time_q  <= 32'h0000_0000;
      byte_count_q <= {(AW + 1){1'b0}};
      sreg_q       <= 7'd0;
      bit_cnt_q    <= 3'd0;
      tmo_q        <= {TW{1'b0}};
      sbf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_time_q  <= trig_time_d;
      byte_count_q <= byte_count_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      sbf_q        <= sbf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Sample RAM write; a byte completing in the reset cycle is discarded
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Registered host read port, one cycle of latency
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign sbf_o        = sbf_q;
  assign rd_data_o    = rd_data_q;
  assign trig_time_o  = trig_time_q;
  assign byte_count_o = byte_count_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
